hb_arbiter: RTL and testbench

Two-requester arbiter and power-up sequencer in front of the HyperBus controller. It shares the controller's single valid/ready memory port between two picorv32-style masters (m0, m1) using round-robin arbitration. Optionally, after reset it issues one configuration-register write (CR0) before granting any master. It sits between the CPU/DMA bus fabric and the HyperBus controller.

---
 rtl/hb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_hb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_arbiter.sv
// hb_arbiter: two-master round-robin arbiter and power-up sequencer placed in front of the
// HyperBus controller's single valid/ready memory port.
//
// Optional feature (compile-time macro HB_ARB_CFG_INIT_EN):
//   defined   - after reset, wait INIT_DELAY cycles, then issue one CR0 write
//               (cfg_access=1, CFG_ADDR, {16'h0, CFG_DATA}, wstrb 4'b0011) before any grant.
//   undefined - reset straight into IDLE with o_init_done = 1; no CR0 write.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_mN_valid/cfg/wstrb/addr/wdata   master N request (N = 0,1), valid held until o_mN_ready
//   o_mN_ready, o_mN_rdata   one-cycle completion pulse and read data (held until next completion)
//   o_hb_valid/cfg/wstrb/addr/wdata   registered request to the controller
//   i_hb_ready, i_hb_rdata   controller completion pulse and read data
//   o_init_done              high once the init sequence has completed
module hb_arbiter #(
    parameter logic [15:0] INIT_DELAY = 16'd150,
    parameter logic [31:0] CFG_ADDR   = 32'h0000_0800,
    parameter logic [15:0] CFG_DATA   = 16'h8F1F
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_m0_valid,
    input  logic        i_m0_cfg,
    input  logic [3:0]  i_m0_wstrb,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_valid,
    input  logic        i_m1_cfg,
    input  logic [3:0]  i_m1_wstrb,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_hb_valid,
    output logic        o_hb_cfg,
    output logic [3:0]  o_hb_wstrb,
    output logic [31:0] o_hb_addr,
    output logic [31:0] o_hb_wdata,
    input  logic        i_hb_ready,
    input  logic [31:0] i_hb_rdata,
    output logic        o_init_done
);

    typedef enum logic [1:0] {StInitWait, StInitCfg, StIdle, StBusy} state_e;

    // With the feature compiled out only the reset values change; the init states become
    // unreachable and are pruned by synthesis.
`ifdef HB_ARB_CFG_INIT_EN
    localparam state_e ResetState    = StInitWait;
    localparam logic   ResetInitDone = 1'b1 ^ 1'b1;
`else
    localparam state_e ResetState    = StIdle;
    localparam logic   ResetInitDone = 1'b1;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rr_q, rr_d;        // 0: m0 wins a tie, 1: m1 wins a tie
    logic        grant_q, grant_d;  // master owning the transaction in flight
    logic        hb_valid_q, hb_valid_d;
    logic        hb_cfg_q, hb_cfg_d;
    logic [3:0]  hb_wstrb_q, hb_wstrb_d;
    logic [31:0] hb_addr_q, hb_addr_d;
    logic [31:0] hb_wdata_q, hb_wdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        init_done_q, init_done_d;
    logic        elig0, elig1, pick;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        hb_valid_d  = hb_valid_q;
        hb_cfg_d    = hb_cfg_q;
        hb_wstrb_d  = hb_wstrb_q;
        hb_addr_d   = hb_addr_q;
        hb_wdata_d  = hb_wdata_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        init_done_d = init_done_q;
        // The ready mask hides a valid that is still held during its own completion cycle.
        elig0 = i_m0_valid & ~m0_ready_q;
        elig1 = i_m1_valid & ~m1_ready_q;
        pick  = (elig0 & elig1) ? rr_q : elig1;

        case (state_q)
            StInitWait: begin
                if (cnt_q == 16'd0) begin
                    hb_valid_d = 1'b1;
                    hb_cfg_d   = 1'b1;
                    hb_wstrb_d = 4'b0011;
                    hb_addr_d  = CFG_ADDR;
                    hb_wdata_d = {16'h0000, CFG_DATA};
                    state_d    = StInitCfg;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StInitCfg: begin
                // CR0 read data is dropped.
                if (i_hb_ready) begin
                    hb_valid_d  = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                if (elig0 | elig1) begin
                    hb_valid_d = 1'b1;
                    grant_d    = pick;
                    hb_cfg_d   = pick ? i_m1_cfg   : i_m0_cfg;
                    hb_wstrb_d = pick ? i_m1_wstrb : i_m0_wstrb;
                    hb_addr_d  = pick ? i_m1_addr  : i_m0_addr;
                    hb_wdata_d = pick ? i_m1_wdata : i_m0_wdata;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (i_hb_ready) begin
                    hb_valid_d = 1'b0;
                    rr_d       = ~grant_q;
                    state_d    = StIdle;
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = i_hb_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = i_hb_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ResetState;
            cnt_q       <= INIT_DELAY;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            hb_valid_q  <= 1'b0;
            hb_cfg_q    <= 1'b0;
            hb_wstrb_q  <= 4'h0;
            hb_addr_q   <= 32'h0;
            hb_wdata_q  <= 32'h0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= 32'h0;
            m1_rdata_q  <= 32'h0;
            init_done_q <= ResetInitDone;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            hb_valid_q  <= hb_valid_d;
            hb_cfg_q    <= hb_cfg_d;
            hb_wstrb_q  <= hb_wstrb_d;
            hb_addr_q   <= hb_addr_d;
            hb_wdata_q  <= hb_wdata_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_hb_valid  = hb_valid_q;
    assign o_hb_cfg    = hb_cfg_q;
    assign o_hb_wstrb  = hb_wstrb_q;
    assign o_hb_addr   = hb_addr_q;
    assign o_hb_wdata  = hb_wdata_q;
    assign o_m0_ready  = m0_ready_q;
    assign o_m1_ready  = m1_ready_q;
    assign o_m0_rdata  = m0_rdata_q;
    assign o_m1_rdata  = m1_rdata_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_hb_arbiter.sv
// tb_hb_arbiter: directed self-checking bench for hb_arbiter. A small controller model answers
// downstream requests after a fixed latency and logs each accepted request; a monitor checks
// ready pulse widths and that no request is presented in the cycle after a completion.
// Honours HB_ARB_CFG_INIT_EN the same way the design does.
`timescale 1ns/1ps
module tb_hb_arbiter;

`ifdef HB_ARB_CFG_INIT_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic        clk, rstn;
    logic        m0_valid, m0_cfg, m0_ready, m1_valid, m1_cfg, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, hb_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        hb_valid, hb_cfg, hb_ready, init_done;
    logic [31:0] hb_addr, hb_wdata, hb_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        ctl_en;
    logic [31:0] ctl_rdata;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    int          m0_pulses = 0;
    int          m1_pulses = 0;
    int          width_err = 0;
    int          reaccept_err = 0;

    hb_arbiter #(
        .INIT_DELAY(16'd4),
        .CFG_ADDR  (32'h0000_0800),
        .CFG_DATA  (16'h8F1F)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_m0_valid (m0_valid),
        .i_m0_cfg   (m0_cfg),
        .i_m0_wstrb (m0_wstrb),
        .i_m0_addr  (m0_addr),
        .i_m0_wdata (m0_wdata),
        .o_m0_ready (m0_ready),
        .o_m0_rdata (m0_rdata),
        .i_m1_valid (m1_valid),
        .i_m1_cfg   (m1_cfg),
        .i_m1_wstrb (m1_wstrb),
        .i_m1_addr  (m1_addr),
        .i_m1_wdata (m1_wdata),
        .o_m1_ready (m1_ready),
        .o_m1_rdata (m1_rdata),
        .o_hb_valid (hb_valid),
        .o_hb_cfg   (hb_cfg),
        .o_hb_wstrb (hb_wstrb),
        .o_hb_addr  (hb_addr),
        .o_hb_wdata (hb_wdata),
        .i_hb_ready (hb_ready),
        .i_hb_rdata (hb_rdata),
        .o_init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!hb_valid && n < max) begin
            step();
            n++;
        end
        check_val("hb_valid_seen", {31'b0, hb_valid}, 32'd1);
    endtask

    task automatic wait_hb_ready(input int max);
        int k = 0;
        while (!hb_ready && k < max) begin
            step();
            k++;
        end
        check_val("hb_ready_seen", {31'b0, hb_ready}, 32'd1);
    endtask

    // Waits for master m's ready pulse and drops that master's valid in the ready cycle.
    task automatic wait_mready(input int m, input int max);
        int k = 0;
        while (((m == 0) ? !m0_ready : !m1_ready) && k < max) begin
            step();
            k++;
        end
        if (m == 0) begin
            check_val("m0_ready_seen", {31'b0, m0_ready}, 32'd1);
            m0_valid = 1'b0;
        end else begin
            check_val("m1_ready_seen", {31'b0, m1_ready}, 32'd1);
            m1_valid = 1'b0;
        end
    endtask

    // Controller model: accepts a request two cycles after seeing valid, one-cycle ready.
    initial begin
        int lat;
        lat      = 0;
        hb_ready = 1'b0;
        hb_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!ctl_en) begin
                lat = 0;
            end else if (!rstn) begin
                hb_ready = 1'b0;
                lat      = 0;
            end else if (hb_ready) begin
                hb_ready = 1'b0;
            end else if (hb_valid) begin
                if (lat >= 2) begin
                    hb_ready = 1'b1;
                    hb_rdata = ctl_rdata;
                    log_addr.push_back(hb_addr);
                    log_wdata.push_back(hb_wdata);
                    lat = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Monitor: ready pulses must be single-cycle and mutually exclusive; no request may be
    // presented in the cycle right after the controller's ready.
    initial begin
        logic p0, p1, pr;
        p0 = 1'b0;
        p1 = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (m0_ready) m0_pulses++;
            if (m1_ready) m1_pulses++;
            if ((m0_ready && p0) || (m1_ready && p1) || (m0_ready && m1_ready)) width_err++;
            if (pr && hb_valid) reaccept_err++;
            p0 = m0_ready;
            p1 = m1_ready;
            pr = hb_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, p0_base, p1_base;
        logic seen;
        rstn = 1'b0;
        ctl_en = 1'b1;
        ctl_rdata = 32'h0;
        m0_valid = 1'b0; m0_cfg = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_cfg = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        repeat (3) step();

        // Reset values
        check_val("rst_hb_valid", {31'b0, hb_valid}, 32'd0);
        check_val("rst_hb_cfg", {31'b0, hb_cfg}, 32'd0);
        check_val("rst_hb_addr", hb_addr, 32'h0);
        check_val("rst_hb_wdata", hb_wdata, 32'h0);
        check_val("rst_hb_wstrb", {28'b0, hb_wstrb}, 32'h0);
        check_val("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        check_val("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        check_val("rst_init_done", {31'b0, init_done}, {31'b0, ~INIT_EN});

`ifdef HB_ARB_CFG_INIT_EN
        // Init sequence with m0 read pending from release
        rstn = 1'b1;
        ctl_rdata = 32'h0BAD_0BAD;
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h100;
        wait_valid(30, n);
        check_val("init_valid_delay", n, 32'd5);
        check_val("cr0_cfg", {31'b0, hb_cfg}, 32'd1);
        check_val("cr0_addr", hb_addr, 32'h800);
        check_val("cr0_wdata", hb_wdata, 32'h0000_8F1F);
        check_val("cr0_wstrb", {28'b0, hb_wstrb}, 32'h3);
        check_val("cr0_init_done", {31'b0, init_done}, 32'd0);
        check_val("cr0_no_m0_pulse", m0_pulses, 32'd0);
        wait_hb_ready(20);
        ctl_rdata = 32'hDEAD_BEEF;
        step();
        check_val("cr0_done", {31'b0, init_done}, 32'd1);
        check_val("cr0_rdata_dropped", m0_rdata, 32'h0);
        check_val("cr0_no_m0_ready", {31'b0, m0_ready}, 32'd0);
`else
        // Feature off: m1 write at release, granted immediately
        rstn = 1'b1;
        ctl_rdata = 32'h1234_5678;
        m1_valid = 1'b1; m1_wstrb = 4'b0100; m1_addr = 32'h40; m1_wdata = 32'hA5A5_A5A5;
        wait_valid(30, n);
        check_val("m1w_latency", n, 32'd1);
        check_val("m1w_wstrb", {28'b0, hb_wstrb}, 32'h4);
        check_val("m1w_addr", hb_addr, 32'h40);
        check_val("m1w_wdata", hb_wdata, 32'hA5A5_A5A5);
        check_val("m1w_cfg", {31'b0, hb_cfg}, 32'd0);
        check_val("m1w_init_done", {31'b0, init_done}, 32'd1);
        wait_mready(1, 30);
        check_val("m1w_rdata", m1_rdata, 32'h1234_5678);
        check_val("m1w_no_m0", {31'b0, m0_ready}, 32'd0);
        step();
        ctl_rdata = 32'hDEAD_BEEF;
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h100;
`endif

        // m0 read of 0x100
        wait_valid(30, n);
        check_val("rd_latency", n, 32'd1);
        check_val("rd_wstrb", {28'b0, hb_wstrb}, 32'h0);
        check_val("rd_addr", hb_addr, 32'h100);
        check_val("rd_cfg", {31'b0, hb_cfg}, 32'd0);
        wait_hb_ready(20);
        check_val("rd_ready_early", {31'b0, m0_ready}, 32'd0);
        step();
        check_val("rd_ready", {31'b0, m0_ready}, 32'd1);
        check_val("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        check_val("rd_no_m1", {31'b0, m1_ready}, 32'd0);
        m0_valid = 1'b0;
        step();
        check_val("rd_pulse_1cyc", {31'b0, m0_ready}, 32'd0);

        // Valid held through the ready cycle must not cause a second transaction
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | hb_valid;
        end
        check_val("no_dup_txn", {31'b0, seen}, 32'd0);

        // m1 read; m0 keeps its last read data
        ctl_rdata = 32'h5555_AAAA;
        m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h140;
        wait_mready(1, 30);
        check_val("m1r_rdata", m1_rdata, 32'h5555_AAAA);
        check_val("m1r_m0_hold", m0_rdata, 32'hDEAD_BEEF);
        check_val("m1r_no_m0", {31'b0, m0_ready}, 32'd0);
        repeat (2) step();

        // Both masters request continuously: strict alternation starting with m0
        base = log_addr.size();
        p0_base = m0_pulses;
        p1_base = m1_pulses;
        m0_valid = 1'b1; m0_wstrb = 4'hF; m0_addr = 32'h200; m0_wdata = 32'h1111_1111;
        m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h300; m1_wdata = 32'h2222_2222;
        n = 0;
        while (log_addr.size() < base + 4 && n < 200) begin
            step();
            n++;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        check_val("rr_count", log_addr.size(), base + 4);
        if (log_addr.size() >= base + 4) begin
            check_val("rr_0_addr", log_addr[base], 32'h200);
            check_val("rr_1_addr", log_addr[base+1], 32'h300);
            check_val("rr_2_addr", log_addr[base+2], 32'h200);
            check_val("rr_3_addr", log_addr[base+3], 32'h300);
            check_val("rr_0_wdata", log_wdata[base], 32'h1111_1111);
            check_val("rr_1_wdata", log_wdata[base+1], 32'h2222_2222);
        end
        repeat (8) step();
        check_val("rr_no_extra", log_addr.size(), base + 4);
        check_val("rr_m0_pulses", m0_pulses - p0_base, 32'd2);
        check_val("rr_m1_pulses", m1_pulses - p1_base, 32'd2);

        // Spurious controller ready while idle
        p0_base = m0_pulses;
        p1_base = m1_pulses;
        ctl_en = 1'b0;
        hb_ready = 1'b1;
        step();
        hb_ready = 1'b0;
        repeat (3) step();
        ctl_en = 1'b1;
        check_val("spur_no_m0", m0_pulses - p0_base, 32'd0);
        check_val("spur_no_m1", m1_pulses - p1_base, 32'd0);
        check_val("spur_no_valid", {31'b0, hb_valid}, 32'd0);

        // Reset while busy
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h180;
        wait_valid(30, n);
        rstn = 1'b0;
        #1;
        check_val("rb_hb_valid", {31'b0, hb_valid}, 32'd0);
        check_val("rb_hb_addr", hb_addr, 32'h0);
        check_val("rb_m0_rdata", m0_rdata, 32'h0);
        check_val("rb_m1_rdata", m1_rdata, 32'h0);
        check_val("rb_init_done", {31'b0, init_done}, {31'b0, ~INIT_EN});
        m0_valid = 1'b0;
        repeat (2) step();

        // Release with both masters pending: m0 has priority after reset
        rstn = 1'b1;
        p0_base = m0_pulses;
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h1C0;
        m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h1E0;
        wait_valid(30, n);
`ifdef HB_ARB_CFG_INIT_EN
        check_val("rb_init_delay", n, 32'd5);
        check_val("rb_cr0_cfg", {31'b0, hb_cfg}, 32'd1);
        check_val("rb_cr0_addr", hb_addr, 32'h800);
        check_val("rb_cr0_no_m0", m0_pulses - p0_base, 32'd0);
`else
        check_val("rb_latency", n, 32'd1);
        check_val("rb_first_addr", hb_addr, 32'h1C0);
`endif
        wait_mready(0, 60);
        wait_mready(1, 60);
        n = log_addr.size();
        check_val("rb_order_m0", log_addr[n-2], 32'h1C0);
        check_val("rb_order_m1", log_addr[n-1], 32'h1E0);
        repeat (4) step();

        check_val("ready_width", width_err, 32'd0);
        check_val("no_reaccept", reaccept_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
